// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between NREQ writeback
// sources, with a pending-write scoreboard used by decode for RAW stall checks.
module rf_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int DW   = 32,
    parameter int AW   = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*AW-1:0]    req_addr,
    input  logic [NREQ*DW-1:0]    req_data,
    output logic                  rf_we,
    output logic [AW-1:0]         rf_waddr,
    output logic [DW-1:0]         rf_wdata,
    input  logic                  claim_valid,
    input  logic [AW-1:0]         claim_addr,
    output logic                  claim_ready,
    input  logic [AW-1:0]         chk_a_addr,
    input  logic [AW-1:0]         chk_b_addr,
    output logic                  chk_a_busy,
    output logic                  chk_b_busy,
    output logic [(2**AW)-1:0]    pend
);

    localparam int PW   = $clog2(NREQ);
    localparam int NREG = 2**AW;

    logic [NREQ-1:0][AW-1:0] addr_v;
    logic [NREQ-1:0][DW-1:0] data_v;
    logic [NREQ-1:0][PW-1:0] cand;

    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic            rf_we_q, rf_we_d;
    logic [AW-1:0]   rf_waddr_q, rf_waddr_d;
    logic [DW-1:0]   rf_wdata_q, rf_wdata_d;
    logic [NREG-1:0] pend_q, pend_d;

    logic            grant_vld;
    logic [PW-1:0]   grant_idx;
    logic [AW-1:0]   grant_addr;
    logic [DW-1:0]   grant_data;
    logic            clr_hit;
    logic            claim_fire;

    assign addr_v = req_addr;
    assign data_v = req_data;

    // cand[k] is the k-th requester visited, starting at rr_ptr and wrapping mod NREQ.
    for (genvar k = 0; k < NREQ; k++) begin : g_cand
        logic [PW:0] sum;
        assign sum     = {1'b0, rr_ptr_q} + (PW+1)'(k);
        assign cand[k] = (sum >= (PW+1)'(NREQ)) ? PW'(sum - (PW+1)'(NREQ)) : PW'(sum);
    end

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_vld && req_valid[cand[k]]) begin
                grant_vld = 1'b1;
                grant_idx = cand[k];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_vld) req_ready[grant_idx] = 1'b1;
    end

    assign grant_addr = addr_v[grant_idx];
    assign grant_data = data_v[grant_idx];

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (grant_vld) begin
            rr_ptr_d   = (grant_idx == PW'(NREQ-1)) ? '0 : grant_idx + PW'(1);
            // r0 writes are accepted and dropped so the RF never sees them.
            rf_we_d    = (grant_addr != '0);
            rf_waddr_d = grant_addr;
            rf_wdata_d = grant_data;
        end
    end

    assign clr_hit     = rf_we_q && (rf_waddr_q == claim_addr);
    assign claim_ready = !pend_q[claim_addr] || clr_hit;
    assign claim_fire  = claim_valid && claim_ready && (claim_addr != '0);

    // Clear first, then set, so a claim colliding with the retiring write keeps the bit.
    always_comb begin
        pend_d = pend_q;
        if (rf_we_q)    pend_d[rf_waddr_q] = 1'b0;
        if (claim_fire) pend_d[claim_addr] = 1'b1;
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_q   <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            pend_q     <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            pend_q     <= pend_d;
        end
    end

    assign rf_we      = rf_we_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;
    assign pend       = pend_q;
    assign chk_a_busy = pend_q[chk_a_addr];
    assign chk_b_busy = pend_q[chk_b_addr];

endmodule
